ppt_pulse_sequencer: RTL and testbench
======================================

// Module: ppt_pulse_sequencer
// PURPOSE
//  Sequences pulsed-plasma-thruster firings from the configuration held in the I2C register map.
//  Consumes clk_div/period/width/count/run_ppt; produces the trigger pulse, count_done and done.
//  Sits between the register map and the PPT trigger pad; all timing is in prescaler ticks.
// PARAMETERS
//  PRESC_W  32  prescaler counter width (must hold 2^(clk_div+1)-1 for clk_div=31)
//  TIM_W    16  width of period/width fields and the phase tick counter
//  CNT_W    8   width of count / count_done
// PORTS
//  clk         in   1      system clock (32.768 kHz oscillator domain)
//  rst         in   1      synchronous reset, active-high
//  clk_div     in   5      tick period = 2^(clk_div+1) clk cycles (9 -> 1024 clk = 32 Hz)
//  period      in   TIM_W  firing period in ticks
//  width       in   TIM_W  pulse high time in ticks
//  count       in   CNT_W  number of firings per run
//  run_ppt     in   1      level: 1 = run/enable, 0 = abort/stop
//  ppt_pulse   out  1      registered trigger output to the thruster
//  count_done  out  CNT_W  firings issued in current/last run
//  done        out  1      run completed all firings
//  busy        out  1      sequence in progress (HIGH or LOW state)
// BEHAVIOUR
//  Reset: state IDLE, ppt_pulse=0, count_done=0, done=0, busy=0, prescaler and tick counter=0.
//  Shadowing: clk_div/period/width/count captured into shadow regs on the IDLE->start cycle;
//   register-map writes during a run take effect only at the next start.
//  Clamping at capture: period<2 -> 2; width=0 -> 1; width>=period -> period-1 (low >= 1 tick).
//  Prescaler: free count 0..2^(clk_div+1)-1, tick on terminal count; cleared on every phase entry,
//   so each phase lasts exactly N*2^(clk_div+1) clk cycles.
//  States:
//   IDLE : run_ppt=1 and done=0 -> capture shadows, done<=0; count=0 -> DONE (no pulse),
//          else -> HIGH, count_done<=1 (1-cycle latency from run_ppt seen to ppt_pulse=1).
//          run_ppt=1 and done=1 -> stay IDLE (re-arm needs run_ppt low first).
//   HIGH : ppt_pulse=1, busy=1; after W ticks -> LOW.
//   LOW  : ppt_pulse=0, busy=1; after P-W ticks: count_done==count -> DONE, done<=1;
//          else -> HIGH, count_done<=count_done+1.
//   DONE : done=1, busy=0, ppt_pulse=0; run_ppt=0 -> IDLE, done stays 1 (readable over I2C).
//  Re-arm: in IDLE with done=1 and run_ppt=0, done cleared; next run_ppt=1 starts a new run and
//   count_done restarts at 1 (it is not cleared between runs until then).
//  Abort: run_ppt=0 in HIGH/LOW -> IDLE next cycle, ppt_pulse=0 next edge, count_done held,
//   done stays 0. Abort takes priority over a simultaneous phase-end tick.
//  count_done never wraps: maximum value is count (<=255).
//  rst mid-run: all outputs to reset values on the next clk edge, pulse truncated.
// STRUCTURE
//  Shared header ppt_defs.vh: state encodings (IDLE/HIGH/LOW/DONE), PERIOD_MIN=2, WIDTH_MIN=1,
//   default widths; also included by the register map for matching field widths.
//  Sub-module ppt_prescaler (clk, rst, clr, clk_div -> tick); the rest is the FSM + tick
//   counter + shadow regs in this module.
// TESTING
//  1 Reset: assert rst 3 cycles mid-pulse -> ppt_pulse=0, count_done=0, done=0, busy=0 after edge.
//  2 Nominal: clk_div=0,period=4,width=1,count=3,run=1 -> 3 pulses of 2 clk high/6 clk low,
//    count_done 1,2,3 at each rising pulse, done=1 at cycle 25 after start, busy=0.
//  3 Abort: same config, run=0 during 2nd HIGH -> pulse low next edge, count_done=2, done=0;
//    run=1 again -> new run, count_done=1 on first pulse.
//  4 count=0, run=1 -> done=1 two cycles later, ppt_pulse never asserted, count_done=0.
//  5 Clamps: width=0,period=4 -> 2 clk high; width=5,period=4 -> 6 clk high, 2 clk low;
//    period=0 -> treated as 2.
//  6 Shadowing/defaults: write period=8 mid-run -> current run unchanged; defaults
//    (clk_div=9,period=128,width=1,count=16) -> 1024 clk high, 130048 clk low, 16 pulses.

Source files
------------

// File: rtl/ppt_pulse_sequencer_pkg.sv
// Shared definitions for the PPT pulse sequencer: FSM states, field widths and
// the minimum legal period/width after clamping.
package ppt_pulse_sequencer_pkg;

  localparam int CLK_DIV_W  = 5;
  localparam int PRESC_W_DF = 32;
  localparam int TIM_W_DF   = 16;
  localparam int CNT_W_DF   = 8;

  localparam int PERIOD_MIN = 2;
  localparam int WIDTH_MIN  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ppt_pulse_sequencer_if.sv
// Register-map side of the sequencer: firing configuration in, run status out.
interface ppt_pulse_sequencer_if
  import ppt_pulse_sequencer_pkg::*;
#(
  parameter int TIM_W = TIM_W_DF,
  parameter int CNT_W = CNT_W_DF
) ();

  logic [CLK_DIV_W-1:0] clk_div;
  logic [TIM_W-1:0]     period;
  logic [TIM_W-1:0]     width;
  logic [CNT_W-1:0]     count;
  logic                 run_ppt;
  logic                 ppt_pulse;
  logic [CNT_W-1:0]     count_done;
  logic                 done;
  logic                 busy;

  modport master (
    output clk_div, period, width, count, run_ppt,
    input  ppt_pulse, count_done, done, busy
  );

  modport slave (
    input  clk_div, period, width, count, run_ppt,
    output ppt_pulse, count_done, done, busy
  );

endinterface

// File: rtl/ppt_pulse_sequencer_prescaler.sv
// Free-running prescaler: one-cycle tick every 2^(clk_div+1) clocks, restartable
// so that each sequencer phase starts on a clean tick boundary.
module ppt_pulse_sequencer_prescaler
  import ppt_pulse_sequencer_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [CLK_DIV_W-1:0] clk_div,
  output logic                 tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_term;

  // All-ones mask of clk_div+1 bits; clk_div=31 yields the full counter range.
  assign w_term = {PRESC_W{1'b1}} >> (PRESC_W - 1 - int'(clk_div));
  assign tick   = (r_cnt == w_term);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr || tick) r_cnt <= '0;
    else                    r_cnt <= r_cnt + PRESC_W'(1);
  end

endmodule

// File: rtl/ppt_pulse_sequencer.sv
// PPT firing sequencer: shadows the register-map configuration at start, then
// alternates HIGH/LOW phases measured in prescaler ticks until count firings.
module ppt_pulse_sequencer
  import ppt_pulse_sequencer_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DF,
  parameter int TIM_W   = TIM_W_DF,
  parameter int CNT_W   = CNT_W_DF
) (
  input  logic           clk,
  input  logic           rst,
  ppt_pulse_sequencer_if.slave sq
);

  state_t               r_state, w_next;
  logic [CLK_DIV_W-1:0] r_clk_div;
  logic [TIM_W-1:0]     r_period, r_width, r_tick_cnt;
  logic [CNT_W-1:0]     r_count, r_count_done;
  logic                 r_done, r_pulse;

  logic                 w_capture, w_tick, w_phase_end, w_presc_clr;
  logic [TIM_W-1:0]     w_period_c, w_width_c, w_phase_len;

  ppt_pulse_sequencer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_presc_clr),
    .clk_div (r_clk_div),
    .tick    (w_tick)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_period_c = sq.period;
    w_width_c  = sq.width;
    if (sq.period < TIM_W'(PERIOD_MIN)) w_period_c = TIM_W'(PERIOD_MIN);
    if (sq.width < TIM_W'(WIDTH_MIN))   w_width_c  = TIM_W'(WIDTH_MIN);
    if (w_width_c >= w_period_c)        w_width_c  = w_period_c - TIM_W'(1);
  end

  assign w_phase_len = (r_state == ST_HIGH) ? r_width : (r_period - r_width);
  assign w_phase_end = w_tick && (r_tick_cnt == w_phase_len - TIM_W'(1));
  assign w_presc_clr = (w_next != r_state);

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: if (sq.run_ppt && !r_done) begin
        w_capture = 1'b1;
        w_next    = (sq.count == '0) ? ST_DONE : ST_HIGH;
      end
      // Abort wins over a coincident phase-end tick.
      ST_HIGH: if (!sq.run_ppt)     w_next = ST_IDLE;
               else if (w_phase_end) w_next = ST_LOW;
      ST_LOW:  if (!sq.run_ppt)     w_next = ST_IDLE;
               else if (w_phase_end) w_next = (r_count_done == r_count) ? ST_DONE : ST_HIGH;
      ST_DONE: if (!sq.run_ppt)     w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: shadow registers are reset too, so a run never starts from X config.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_div    <= '0;
      r_period     <= '0;
      r_width      <= '0;
      r_count      <= '0;
      r_tick_cnt   <= '0;
      r_count_done <= '0;
      r_done       <= 1'b0;
      r_pulse      <= 1'b0;
    end else begin
      r_pulse <= (w_next == ST_HIGH);

      if (w_capture) begin
        r_clk_div <= sq.clk_div;
        r_period  <= w_period_c;
        r_width   <= w_width_c;
        r_count   <= sq.count;
      end

      if (w_presc_clr) r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= r_tick_cnt + TIM_W'(1);

      if (w_capture)
        r_count_done <= (sq.count == '0) ? '0 : CNT_W'(1);
      else if (r_state == ST_LOW && w_next == ST_HIGH)
        r_count_done <= r_count_done + CNT_W'(1);

      // done survives DONE->IDLE for one cycle, then clears while run_ppt is low.
      if (w_capture)
        r_done <= 1'b0;
      else if (r_state == ST_DONE || (r_state == ST_LOW && w_next == ST_DONE))
        r_done <= 1'b1;
      else if (r_state == ST_IDLE && !sq.run_ppt)
        r_done <= 1'b0;
    end
  end

  assign sq.ppt_pulse  = r_pulse;
  assign sq.count_done = r_count_done;
  assign sq.done       = r_done;
  assign sq.busy       = (r_state == ST_HIGH) || (r_state == ST_LOW);

endmodule

// File: tb/tb_ppt_pulse_sequencer.sv
// Self-checking bench: each run is compared cycle by cycle against a closed-form
// waveform model derived from period/width/count/clk_div.
module tb_ppt_pulse_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppt_pulse_sequencer_if #(.TIM_W(16), .CNT_W(8)) sq ();

  ppt_pulse_sequencer #(.PRESC_W(32), .TIM_W(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int clk_div;
    int period;
    int width;
    int count;
  } cfg_t;

  // Expected {pulse, busy, done, count_done} n edges after the start edge (n=1 first).
  function automatic logic [10:0] model(input cfg_t c, input int n);
    longint t, per, total, k, off;
    int p, w;
    t = longint'(1) << (c.clk_div + 1);
    p = (c.period < 2) ? 2 : c.period;
    w = (c.width == 0) ? 1 : c.width;
    if (w >= p) w = p - 1;
    per   = longint'(p) * t;
    total = per * longint'(c.count);
    if (c.count == 0) return {1'b0, 1'b0, (n >= 2), 8'd0};
    if (longint'(n) <= total) begin
      k   = (longint'(n) - 1) / per;
      off = (longint'(n) - 1) % per;
      return {(off < longint'(w) * t), 1'b1, 1'b0, 8'(k + 1)};
    end
    return {1'b0, 1'b0, 1'b1, 8'(c.count)};
  endfunction

  function automatic int run_len(input cfg_t c);
    int p, tot;
    p = (c.period < 2) ? 2 : c.period;
    if (c.count == 0) return 2;
    tot = p * (1 << (c.clk_div + 1)) * c.count;
    return tot + 1;
  endfunction

  function automatic logic [10:0] observed();
    return {sq.ppt_pulse, sq.busy, sq.done, sq.count_done};
  endfunction

  task automatic compare(input string name, input int n, input logic [10:0] exp);
    logic [10:0] act;
    act = observed();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d pulse/busy/done/count_done got %b/%b/%b/%0d want %b/%b/%b/%0d",
               name, n, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    sq.clk_div = 5'(c.clk_div);
    sq.period  = 16'(c.period);
    sq.width   = 16'(c.width);
    sq.count   = 8'(c.count);
  endtask

  // Starts a run from IDLE (done=0), checks every cycle, optionally aborts at sample
  // abort_n, scrambles the register-map inputs mid-run, then checks stop and re-arm.
  task automatic do_run(input string name, input cfg_t c, input int abort_n, input bit scramble);
    logic [10:0] last;
    int  end_n;
    bit  aborted;
    end_n   = run_len(c);
    aborted = (abort_n > 0) && (abort_n < end_n);
    last    = '0;
    apply_cfg(c);
    sq.run_ppt = 1'b1;
    for (int n = 1; n <= end_n; n++) begin
      @(negedge clk);
      last = model(c, n);
      compare(name, n, last);
      if (scramble) begin
        sq.clk_div = 5'($urandom_range(0, 3));
        sq.period  = 16'($urandom_range(0, 12));
        sq.width   = 16'($urandom_range(0, 12));
        sq.count   = 8'($urandom_range(0, 6));
      end
      if (n == abort_n) break;
    end
    sq.run_ppt = 1'b0;
    @(negedge clk);
    compare({name, "_stop"}, 0, {1'b0, 1'b0, !aborted, last[7:0]});
    @(negedge clk);
    compare({name, "_rearm"}, 0, {1'b0, 1'b0, 1'b0, last[7:0]});
  endtask

  task automatic test_reset();
    cfg_t c;
    rst = 1'b1;
    sq.run_ppt = 1'b0;
    repeat (2) @(negedge clk);
    compare("reset_init", 0, 11'd0);
    rst = 1'b0;
    c = '{0, 4, 1, 3};
    apply_cfg(c);
    sq.run_ppt = 1'b1;
    @(negedge clk);
    compare("reset_prepulse", 1, model(c, 1));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare("reset_midpulse", i, 11'd0);
    end
    rst = 1'b0;
    sq.run_ppt = 1'b0;
    @(negedge clk);
    compare("reset_release", 0, 11'd0);
  endtask

  task automatic test_nominal();
    do_run("nominal", '{0, 4, 1, 3}, 0, 1'b0);
  endtask

  task automatic test_abort();
    do_run("abort_2nd_high", '{0, 4, 1, 3}, 9, 1'b0);
    do_run("abort_restart", '{0, 4, 1, 3}, 0, 1'b0);
    do_run("abort_low", '{1, 5, 2, 4}, 15, 1'b0);
  endtask

  task automatic test_count_zero();
    do_run("count_zero", '{0, 4, 1, 0}, 0, 1'b0);
  endtask

  task automatic test_clamps();
    do_run("clamp_width0", '{0, 4, 0, 2}, 0, 1'b0);
    do_run("clamp_width_ge_period", '{0, 4, 5, 2}, 0, 1'b0);
    do_run("clamp_period0", '{0, 0, 1, 2}, 0, 1'b0);
    do_run("clamp_period1", '{1, 1, 3, 1}, 0, 1'b0);
  endtask

  task automatic test_shadowing();
    do_run("shadow_nominal", '{0, 4, 1, 3}, 0, 1'b1);
    do_run("shadow_defaults", '{9, 128, 1, 16}, 3000, 1'b1);
  endtask

  task automatic test_random();
    cfg_t c;
    int   ab;
    for (int r = 0; r < 30; r++) begin
      c.clk_div = int'($urandom_range(0, 2));
      c.period  = int'($urandom_range(0, 6));
      c.width   = int'($urandom_range(0, 7));
      c.count   = int'($urandom_range(0, 4));
      ab = 0;
      if (c.count != 0 && $urandom_range(0, 2) == 0)
        ab = int'($urandom_range(1, run_len(c) - 1));
      do_run($sformatf("random%0d", r), c, ab, 1'b1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sq.clk_div = '0;
    sq.period  = '0;
    sq.width   = '0;
    sq.count   = '0;
    sq.run_ppt = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_abort();
    test_count_zero();
    test_clamps();
    test_shadowing();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
